// File: rtl/adc_meas_pkg.sv
// adc_meas_pkg
// Shared definitions for the ADC waveform measurement block:
//   - default sample width and zero-crossing reference / hysteresis levels
//   - crossing detector state encoding
//   - counter width helper used for the divider, gate and symbol counters
package adc_meas_pkg;

    localparam int DEF_DATA_W = 8;
    localparam int DEF_MID    = 128;
    localparam int DEF_HYST   = 8;

    typedef enum logic {
        ST_LOW  = 1'b0,
        ST_HIGH = 1'b1
    } cross_state_t;

    // Width needed to count 0..n-1; never narrower than one bit.
    function automatic int ctr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/adc_pkpk_tracker.sv
// adc_pkpk_tracker
// Running max/min tracker over a window of ADC samples.
// Ports:
//   clk, rst_n   system clock, asynchronous active-low reset
//   sample       sample value, considered when strobe is high
//   strobe       sample qualifier
//   clear        start a new window; a sample strobed in the same cycle
//                becomes the first sample of the new window
//   sample_max   largest sample in the current window (0 when empty)
//   sample_min   smallest sample in the current window (all-ones when empty)
//   pkpk         sample_max - sample_min, 0 for an empty window
module adc_pkpk_tracker
    import adc_meas_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] sample,
    input  logic              strobe,
    input  logic              clear,
    output logic [DATA_W-1:0] sample_max,
    output logic [DATA_W-1:0] sample_min,
    output logic [DATA_W-1:0] pkpk
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_max <= '0;
            sample_min <= '1;
        end else if (clear) begin
            sample_max <= strobe ? sample : '0;
            sample_min <= strobe ? sample : '1;
        end else if (strobe) begin
            if (sample > sample_max) sample_max <= sample;
            if (sample < sample_min) sample_min <= sample;
        end
    end

    // An empty window has max < min; report zero instead of a wrapped value.
    assign pkpk = (sample_max >= sample_min) ? (sample_max - sample_min) : '0;

endmodule

// File: rtl/adc_wave_meas.sv
// adc_wave_meas
// Capture side of the AD/DA loop: generates the ADC conversion clock,
// registers samples and measures the incoming waveform over a fixed gate:
// frequency as a count of rising hysteresis zero-crossings, amplitude as
// the peak-to-peak spread of the samples.
// Optional feature: define ASK_DEMOD_EN to add an ASK demodulator that
// decides one bit per SYM_CYCLES window from the window's peak-to-peak.
// Ports:
//   clk        system clock
//   rst_n      asynchronous active-low reset
//   adc_data   ADC parallel output, offset binary
//   adc_clk    ADC conversion clock, clk/(2*ADC_DIV)
//   freq_cnt   rising crossings counted in the last gate
//   vpp        max-min of the samples in the last gate
//   meas_valid one-cycle pulse when freq_cnt/vpp update
//   ask_bit    demodulated ASK bit (0 without ASK_DEMOD_EN)
//   ask_valid  one-cycle pulse per ASK symbol (0 without ASK_DEMOD_EN)
module adc_wave_meas
    import adc_meas_pkg::*;
#(
    parameter int DATA_W      = DEF_DATA_W,
    parameter int ADC_DIV     = 2,
    parameter int GATE_CYCLES = 50_000_000,
    parameter int CNT_W       = 24,
    parameter int MID         = DEF_MID,
    parameter int HYST        = DEF_HYST,
    parameter int SYM_CYCLES  = 5000,
    parameter int ASK_THR     = 64
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] adc_data,
    output logic              adc_clk,
    output logic [CNT_W-1:0]  freq_cnt,
    output logic [DATA_W-1:0] vpp,
    output logic              meas_valid,
    output logic              ask_bit,
    output logic              ask_valid
);

    localparam int DIV_W  = ctr_width(ADC_DIV);
    localparam int GATE_W = ctr_width(GATE_CYCLES);

    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(ADC_DIV - 1);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [DATA_W-1:0] HI_LVL    = DATA_W'(MID + HYST);
    localparam logic [DATA_W-1:0] LO_LVL    = DATA_W'(MID - HYST);

    logic [DIV_W-1:0]  div_cnt;
    logic              sample_stb;
    logic [DATA_W-1:0] sample_q;
    logic              sample_vld;
    cross_state_t      cross_state;
    logic              cross_inc;
    logic [CNT_W-1:0]  cross_cnt;
    logic [CNT_W-1:0]  cross_cnt_next;
    logic [GATE_W-1:0] gate_cnt;
    logic              gate_wrap;
    logic [DATA_W-1:0] gate_pkpk;
    logic [DATA_W-1:0] unused_gate_max;
    logic [DATA_W-1:0] unused_gate_min;

    // The ADC latches on the falling edge of adc_clk, so that is where we
    // capture its output too.
    assign sample_stb = (div_cnt == DIV_LAST) && adc_clk;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt <= '0;
            adc_clk <= 1'b0;
        end else if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            adc_clk <= ~adc_clk;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q   <= '0;
            sample_vld <= 1'b0;
        end else begin
            sample_vld <= sample_stb;
            if (sample_stb) sample_q <= adc_data;
        end
    end

    // Rising crossing: a LOW->HIGH transition; the count saturates.
    assign cross_inc      = sample_vld && (cross_state == ST_LOW) && (sample_q >= HI_LVL);
    assign cross_cnt_next = (cross_inc && (cross_cnt != '1)) ? (cross_cnt + CNT_W'(1)) : cross_cnt;

    // Hysteresis detector; its state carries across gate boundaries so a
    // waveform straddling the boundary is not double counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cross_state <= ST_LOW;
        end else if (sample_vld) begin
            case (cross_state)
                ST_LOW:  if (sample_q >= HI_LVL) cross_state <= ST_HIGH;
                ST_HIGH: if (sample_q <= LO_LVL) cross_state <= ST_LOW;
                default: cross_state <= ST_LOW;
            endcase
        end
    end

    assign gate_wrap = (gate_cnt == GATE_LAST);

    // A crossing detected on the wrap cycle still belongs to the closing
    // gate, hence freq_cnt takes cross_cnt_next rather than cross_cnt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gate_cnt   <= '0;
            cross_cnt  <= '0;
            freq_cnt   <= '0;
            vpp        <= '0;
            meas_valid <= 1'b0;
        end else begin
            meas_valid <= gate_wrap;
            if (gate_wrap) begin
                gate_cnt  <= '0;
                cross_cnt <= '0;
                freq_cnt  <= cross_cnt_next;
                vpp       <= gate_pkpk;
            end else begin
                gate_cnt  <= gate_cnt + GATE_W'(1);
                cross_cnt <= cross_cnt_next;
            end
        end
    end

    // A sample landing on the wrap cycle opens the next gate's window.
    adc_pkpk_tracker #(.DATA_W(DATA_W)) u_gate_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample_q),
        .strobe     (sample_vld),
        .clear      (gate_wrap),
        .sample_max (unused_gate_max),
        .sample_min (unused_gate_min),
        .pkpk       (gate_pkpk)
    );

`ifdef ASK_DEMOD_EN
    localparam int SYM_W = ctr_width(SYM_CYCLES);
    localparam logic [SYM_W-1:0]  SYM_LAST = SYM_W'(SYM_CYCLES - 1);
    localparam logic [DATA_W-1:0] ASK_LVL  = DATA_W'(ASK_THR);

    logic [SYM_W-1:0]  sym_cnt;
    logic              sym_wrap;
    logic [DATA_W-1:0] sym_pkpk;
    logic [DATA_W-1:0] unused_sym_max;
    logic [DATA_W-1:0] unused_sym_min;

    assign sym_wrap = (sym_cnt == SYM_LAST);

    // Symbol windows free-run independently of the measurement gate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sym_cnt   <= '0;
            ask_bit   <= 1'b0;
            ask_valid <= 1'b0;
        end else begin
            ask_valid <= sym_wrap;
            if (sym_wrap) begin
                sym_cnt <= '0;
                ask_bit <= (sym_pkpk >= ASK_LVL);
            end else begin
                sym_cnt <= sym_cnt + SYM_W'(1);
            end
        end
    end

    adc_pkpk_tracker #(.DATA_W(DATA_W)) u_sym_trk (
        .clk        (clk),
        .rst_n      (rst_n),
        .sample     (sample_q),
        .strobe     (sample_vld),
        .clear      (sym_wrap),
        .sample_max (unused_sym_max),
        .sample_min (unused_sym_min),
        .pkpk       (sym_pkpk)
    );
`else
    logic unused_ask_cfg;
    assign unused_ask_cfg = ((SYM_CYCLES + ASK_THR) != 0);
    assign ask_bit   = 1'b0;
    assign ask_valid = 1'b0;
`endif

endmodule

// File: tb/tb_adc_wave_meas.sv
// tb_adc_wave_meas
// Directed bench for adc_wave_meas with a short gate (2001 clk cycles) so
// several gates fit in a short run. The waveform value is a function of the
// sample index j = cycle/4 counted from reset release, which makes every
// gate's crossing count and peak-to-peak hand-computable.
// With GATE_CYCLES=2001 the first gate closes on the same cycle that
// processes sample 499, so the gate-wrap crossing case is reachable.
// Build with ASK_DEMOD_EN defined to exercise the ASK demodulator.
module tb_adc_wave_meas;

    localparam int DW         = 8;
    localparam int CW         = 24;
    localparam int GATE       = 2001;
    localparam int SYM        = 400;
    localparam int BUDGET     = 2100;

    localparam int MODE_SINE   = 1;
    localparam int MODE_CONST  = 2;
    localparam int MODE_NOISE  = 3;
    localparam int MODE_SQUARE = 4;
    localparam int MODE_STEP   = 5;
    localparam int MODE_ASK    = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] adc_data;
    logic          adc_clk;
    logic [CW-1:0] freq_cnt;
    logic [DW-1:0] vpp;
    logic          meas_valid;
    logic          ask_bit;
    logic          ask_valid;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int mode     = 0;
    int at;

    adc_wave_meas #(
        .DATA_W      (DW),
        .ADC_DIV     (2),
        .GATE_CYCLES (GATE),
        .CNT_W       (CW),
        .MID         (128),
        .HYST        (8),
        .SYM_CYCLES  (SYM),
        .ASK_THR     (64)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .adc_data   (adc_data),
        .adc_clk    (adc_clk),
        .freq_cnt   (freq_cnt),
        .vpp        (vpp),
        .meas_valid (meas_valid),
        .ask_bit    (ask_bit),
        .ask_valid  (ask_valid)
    );

    always #10 clk = ~clk;

    // Input waveform seen by the ADC before edge k; only j = k/4 matters
    // because samples are captured on edges 3, 7, 11, ...
    function automatic logic [DW-1:0] wave(input int m, input int k);
        int  j;
        int  a;
        real r;
        j = k / 4;
        case (m)
            MODE_SINE: begin
                r = 100.0 * $sin(2.0 * 3.14159265358979 * j / 48.0);
                return DW'(128 + $rtoi($floor(r + 0.5)));
            end
            MODE_CONST:  return DW'(128);
            MODE_NOISE:  return DW'(122 + (j * 7) % 13);
            MODE_SQUARE: return ((j % 25) < 12) ? DW'(160) : DW'(100);
            MODE_STEP:   return (j < 499) ? DW'(100 + 10 * (j % 2)) : DW'(160 + 10 * (j % 2));
            MODE_ASK: begin
                a = ((((j + 1) / 100) % 2) == 0) ? 100 : 10;
                return (j % 2 == 1) ? DW'(128 + a) : DW'(128 - a);
            end
            default: return DW'(0);
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input int n);
        repeat (n) begin
            @(negedge clk);
            adc_data = wave(mode, cyc);
            cyc++;
        end
    endtask

    // Returns the cycle index at which meas_valid was seen, or -1.
    task automatic run_to_meas(input int budget, output int seen_at);
        seen_at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (meas_valid) seen_at = cyc;
            adc_data = wave(mode, cyc);
            cyc++;
            if (seen_at >= 0) break;
        end
        if (seen_at < 0) check_output("meas_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_reset(input int m);
        @(negedge clk);
        rst_n    = 1'b0;
        adc_data = '0;
        repeat (3) @(negedge clk);
        mode     = m;
        cyc      = 0;
        rst_n    = 1'b1;
        adc_data = wave(m, 0);
        cyc      = 1;
    endtask

    initial begin
        int n_sym;
        int seen;

        // Reset state
        rst_n    = 1'b1;
        adc_data = '0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_output("rst_freq",  32'(freq_cnt),   32'd0);
        check_output("rst_vpp",   32'(vpp),        32'd0);
        check_output("rst_valid", 32'(meas_valid), 32'd0);
        check_output("rst_askb",  32'(ask_bit),    32'd0);
        check_output("rst_askv",  32'(ask_valid),  32'd0);
        repeat (3) begin
            @(negedge clk);
            check_output("rst_adcclk", 32'(adc_clk), 32'd0);
        end

        // Release: adc_clk rises after edge 1, falls after edge 3 (80 ns period)
        @(negedge clk);
        mode     = MODE_SINE;
        cyc      = 0;
        rst_n    = 1'b1;
        adc_data = wave(mode, 0);
        cyc      = 1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check_output("adc_clk_wave", 32'(adc_clk), 32'((cyc >> 1) & 1));
            adc_data = wave(mode, cyc);
            cyc++;
        end

        // 48-sample sine 28..228: 11 crossings in gate 1, 10 in gate 2
        run_to_meas(BUDGET, at);
        check_output("sine_g1_at",   32'(at),       32'd2001);
        check_output("sine_g1_freq", 32'(freq_cnt), 32'd11);
        check_output("sine_g1_vpp",  32'(vpp),      32'd200);
        apply_stimulus(1);
        check_output("meas_pulse_1cyc", 32'(meas_valid), 32'd0);
        run_to_meas(BUDGET, at);
        check_output("sine_g2_at",   32'(at),       32'd4002);
        check_output("sine_g2_freq", 32'(freq_cnt), 32'd10);
        check_output("sine_g2_vpp",  32'(vpp),      32'd200);
        apply_stimulus(50);
        check_output("sine_hold_freq", 32'(freq_cnt), 32'd10);

        // Mid-gate reset discards the partial gate
        apply_stimulus(900);
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_output("midrst_valid",  32'(meas_valid), 32'd0);
            check_output("midrst_adcclk", 32'(adc_clk),    32'd0);
        end
        check_output("midrst_freq", 32'(freq_cnt), 32'd0);
        check_output("midrst_vpp",  32'(vpp),      32'd0);
        do_reset(MODE_SINE);
        run_to_meas(BUDGET, at);
        check_output("midrst_g1_at",   32'(at),       32'd2001);
        check_output("midrst_g1_freq", 32'(freq_cnt), 32'd11);
        check_output("midrst_g1_vpp",  32'(vpp),      32'd200);

        // Constant mid-scale
        do_reset(MODE_CONST);
        run_to_meas(BUDGET, at);
        check_output("const_freq", 32'(freq_cnt), 32'd0);
        check_output("const_vpp",  32'(vpp),      32'd0);

        // Noise 122..134 stays inside the hysteresis band
        do_reset(MODE_NOISE);
        run_to_meas(BUDGET, at);
        check_output("noise_freq", 32'(freq_cnt), 32'd0);
        check_output("noise_vpp",  32'(vpp),      32'd12);

        // Square 100/160, 25-sample period
        do_reset(MODE_SQUARE);
        run_to_meas(BUDGET, at);
        check_output("sq_g1_freq", 32'(freq_cnt), 32'd20);
        check_output("sq_g1_vpp",  32'(vpp),      32'd60);
        run_to_meas(BUDGET, at);
        check_output("sq_g2_freq", 32'(freq_cnt), 32'd20);
        check_output("sq_g2_vpp",  32'(vpp),      32'd60);

        // Step crossing on the gate-wrap cycle: counted in the old gate,
        // while its sample opens the new peak-to-peak window
        do_reset(MODE_STEP);
        run_to_meas(BUDGET, at);
        check_output("wrap_g1_freq", 32'(freq_cnt), 32'd1);
        check_output("wrap_g1_vpp",  32'(vpp),      32'd10);
        run_to_meas(BUDGET, at);
        check_output("wrap_g2_freq", 32'(freq_cnt), 32'd0);
        check_output("wrap_g2_vpp",  32'(vpp),      32'd10);

        // ASK symbols: pk-pk 200 / 20 alternating per 400-cycle window
        do_reset(MODE_ASK);
`ifdef ASK_DEMOD_EN
        n_sym = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (ask_valid) begin
                check_output("ask_time", 32'(cyc), 32'(SYM * (n_sym + 1)));
                check_output("ask_bit",  32'(ask_bit), 32'((n_sym % 2) == 0));
                n_sym++;
            end
            adc_data = wave(mode, cyc);
            cyc++;
        end
        check_output("ask_count", 32'(n_sym), 32'd3);
`else
        seen = 0;
        for (int i = 0; i < 1300; i++) begin
            @(negedge clk);
            if (ask_bit !== 1'b0 || ask_valid !== 1'b0) seen++;
            adc_data = wave(mode, cyc);
            cyc++;
        end
        check_output("ask_stuck", 32'(seen), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
